// File: rtl/flit_packetizer_if.sv
// Link bundle for the flit packetizer: destination and payload handshakes on
// the upstream side, the flit link to the router on the downstream side.
interface flit_packetizer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TYPE_WIDTH = 2,
    parameter int DEST_WIDTH = 4
);
    localparam int PW = DATA_WIDTH - TYPE_WIDTH;

    logic [DEST_WIDTH-1:0] dest_in;
    logic                  dest_valid;
    logic                  dest_ready;
    logic [PW-1:0]         payload_in;
    logic                  payload_valid;
    logic                  payload_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_out;
    logic                  busy;

    // Traffic source / flit sink side
    modport master (
        output dest_in, dest_valid, payload_in, payload_valid, ready_out,
        input  dest_ready, payload_ready, data_out, valid_out, busy
    );

    // Packetizer side
    modport slave (
        input  dest_in, dest_valid, payload_in, payload_valid, ready_out,
        output dest_ready, payload_ready, data_out, valid_out, busy
    );
endinterface

// File: rtl/flit_packetizer.sv
// Source-side network interface: wraps a destination plus FlitPerPacket-1
// payload words into a head/body.../tail wormhole packet, one flit per cycle.
module flit_packetizer #(
    parameter int INDEX         = 1,
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int DEST_WIDTH    = 4,
    parameter int FlitPerPacket = 6
) (
    input  logic             clk,
    input  logic             rst,
    flit_packetizer_if.slave bus
);
    localparam int CW = $clog2(FlitPerPacket);

    localparam logic [TYPE_WIDTH-1:0] T_HEAD = TYPE_WIDTH'(2'b01);
    localparam logic [TYPE_WIDTH-1:0] T_BODY = TYPE_WIDTH'(2'b10);
    localparam logic [TYPE_WIDTH-1:0] T_TAIL = TYPE_WIDTH'(2'b11);
    localparam logic [DEST_WIDTH-1:0] SRC_ID = DEST_WIDTH'(INDEX);
    // Count value of the last body flit; unused when a packet has no bodies
    localparam logic [CW-1:0] LAST_BODY = CW'((FlitPerPacket >= 3) ? FlitPerPacket - 3 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_TAIL
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  load_ok;
    logic                  dest_hs;
    logic                  pay_hs;
    logic [DATA_WIDTH-1:0] head_flit;

    // The output register can take a new flit when empty or being drained this cycle
    assign load_ok = !valid_q || bus.ready_out;

    assign bus.dest_ready    = rst && (state == S_IDLE) && load_ok;
    assign bus.payload_ready = rst && (state != S_IDLE) && load_ok;
    assign dest_hs           = bus.dest_valid && bus.dest_ready;
    assign pay_hs            = bus.payload_valid && bus.payload_ready;

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.busy      = busy_q;

    // Head flit: type, zero padding, source index, destination index
    always_comb begin
        head_flit = '0;
        head_flit[DATA_WIDTH-1 -: TYPE_WIDTH]   = T_HEAD;
        head_flit[2*DEST_WIDTH-1 -: DEST_WIDTH] = SRC_ID;
        head_flit[DEST_WIDTH-1:0]               = bus.dest_in;
    end

    // Packet FSM and output register; reset drops any half-sent packet
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (dest_hs) begin
                data_q  <= head_flit;
                valid_q <= 1'b1;
                busy_q  <= 1'b1;
                cnt     <= '0;
                state   <= (FlitPerPacket == 2) ? S_TAIL : S_BODY;
            end else if (pay_hs) begin
                valid_q <= 1'b1;
                if (state == S_BODY) begin
                    data_q <= {T_BODY, bus.payload_in};
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BODY) begin
                        state <= S_TAIL;
                    end
                end else begin
                    data_q <= {T_TAIL, bus.payload_in};
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            end else if (bus.ready_out) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule
